// File: rtl/seg7_capture.sv
// seg7_capture
//   Receive side of a time-multiplexed 4-digit 7-segment display bus.
//   Samples the segment lines and one-hot digit enable, waits until a
//   {digit, pattern} sample has been steady for STABLE_CNT cycles, then
//   decodes the lit pattern back to a hex nibble for that digit.
//
// Parameters
//   STABLE_CNT     : consecutive identical synced samples needed to commit (1..255)
//   SEG_ACTIVE_LOW : 1 = a low segment line means lit, 0 = a high line means lit
//
// Ports
//   Clk         : rising-edge clock
//   Rst         : asynchronous active-high reset
//   Seg_in      : segment lines, bit0=a (top) .. bit6=g (middle)
//   Dig_en      : one-hot digit enable, bit n selects digit n
//   Digits      : recovered nibbles, digit n at [4n+3:4n]
//   Digit_valid : per digit, last commit was a legal hex glyph
//   Frame_done  : one-cycle pulse once all four digits have committed
//   Pat_err     : one-cycle pulse on commit of an illegal pattern
//   Err_digit   : digit index of the most recent illegal commit
//
// Optional build macro SEG7_CAP_DP_EN
//   Adds input Seg_dp (decimal point, same polarity as Seg_in), which joins
//   the stability compare, and output Dp_out, where bit n holds the DP state
//   seen on the latest commit of digit n. DP never affects decoding.
module seg7_capture #(
    parameter int STABLE_CNT     = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [6:0]  Seg_in,
    input  logic [3:0]  Dig_en,
`ifdef SEG7_CAP_DP_EN
    input  logic        Seg_dp,
    output logic [3:0]  Dp_out,
`endif
    output logic [15:0] Digits,
    output logic [3:0]  Digit_valid,
    output logic        Frame_done,
    output logic        Pat_err,
    output logic [1:0]  Err_digit
);

`ifdef SEG7_CAP_DP_EN
    localparam int SW = 8;
    logic [SW-1:0] raw;
    assign raw = {Seg_dp, Seg_in};
`else
    localparam int SW = 7;
    logic [SW-1:0] raw;
    assign raw = Seg_in;
`endif

    localparam logic [7:0] STABLE = 8'(STABLE_CNT);

    logic [SW-1:0] seg_s1, seg_s2;
    logic [3:0]    en_s1, en_s2;
    logic [SW-1:0] lit;
    logic [SW+3:0] prev;
    logic [7:0]    cnt, cnt_next;
    logic          onehot, same, commit;
    logic [1:0]    idx;
    logic [3:0]    seen, seen_next;
    logic [4:0]    dec;

    // Lit pattern to {legal, value}; anything not in the table is illegal.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F:   decode = {1'b1, 4'h0};
            7'h06:   decode = {1'b1, 4'h1};
            7'h5B:   decode = {1'b1, 4'h2};
            7'h4F:   decode = {1'b1, 4'h3};
            7'h66:   decode = {1'b1, 4'h4};
            7'h6D:   decode = {1'b1, 4'h5};
            7'h7D:   decode = {1'b1, 4'h6};
            7'h07:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h6F:   decode = {1'b1, 4'h9};
            7'h77:   decode = {1'b1, 4'hA};
            7'h7C:   decode = {1'b1, 4'hB};
            7'h39:   decode = {1'b1, 4'hC};
            7'h5E:   decode = {1'b1, 4'hD};
            7'h79:   decode = {1'b1, 4'hE};
            7'h71:   decode = {1'b1, 4'hF};
            default: decode = 5'b0_0000;
        endcase
    endfunction

    // Polarity is normalised after the synchroniser so 1 = lit internally.
    assign lit = SEG_ACTIVE_LOW ? ~seg_s2 : seg_s2;

    always_comb begin
        onehot    = 1'b0;
        same      = 1'b0;
        cnt_next  = 8'd0;
        commit    = 1'b0;
        idx       = 2'd0;
        seen_next = seen;
        dec       = decode(lit[6:0]);

        onehot = (en_s2 != 4'd0) && ((en_s2 & (en_s2 - 4'd1)) == 4'd0);
        same   = ({en_s2, lit} == prev);

        if (same && onehot)
            cnt_next = (cnt == STABLE) ? cnt : cnt + 8'd1;
        else
            cnt_next = onehot ? 8'd1 : 8'd0;

        // Commit only on the arrival at STABLE, never while sitting there.
        // A fresh sample reloading to 1 counts as an arrival when STABLE is 1.
        commit = onehot && (cnt_next == STABLE) && !(same && (cnt == STABLE));

        case (en_s2)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase

        seen_next = seen | en_s2;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            seg_s1      <= '0;
            seg_s2      <= '0;
            en_s1       <= 4'd0;
            en_s2       <= 4'd0;
            prev        <= '0;
            cnt         <= 8'd0;
            seen        <= 4'd0;
            Digits      <= 16'd0;
            Digit_valid <= 4'd0;
            Frame_done  <= 1'b0;
            Pat_err     <= 1'b0;
            Err_digit   <= 2'd0;
`ifdef SEG7_CAP_DP_EN
            Dp_out      <= 4'd0;
`endif
        end else begin
            seg_s1     <= raw;
            seg_s2     <= seg_s1;
            en_s1      <= Dig_en;
            en_s2      <= en_s1;
            prev       <= {en_s2, lit};
            cnt        <= cnt_next;
            Frame_done <= 1'b0;
            Pat_err    <= 1'b0;
            if (commit) begin
                // Blank and illegal commits still count toward the frame.
                if (seen_next == 4'hF) begin
                    Frame_done <= 1'b1;
                    seen       <= 4'd0;
                end else begin
                    seen <= seen_next;
                end

                if (lit[6:0] == 7'd0) begin
                    Digit_valid[idx] <= 1'b0;
                end else if (dec[4]) begin
                    Digits[{idx, 2'b00} +: 4] <= dec[3:0];
                    Digit_valid[idx]          <= 1'b1;
                end else begin
                    Digit_valid[idx] <= 1'b0;
                    Pat_err          <= 1'b1;
                    Err_digit        <= idx;
                end
`ifdef SEG7_CAP_DP_EN
                Dp_out[idx] <= lit[7];
`endif
            end
        end
    end

endmodule
